// File: rtl/march_cminus_seq_pkg.sv
// march_pkg: shared types and March C- element tables for the BIST sequencer.
//   march_state_t : sequencer FSM states
//   march_val_t   : data value used by an element op (none / D0 / D1)
//   M0..M5        : element codes
//   elem_is_up / elem_rd_val / elem_wr_val : per-element direction and op tables
package march_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } march_state_t;

  typedef enum logic [1:0] {
    VAL_NONE = 2'd0,
    VAL_0    = 2'd1,
    VAL_1    = 2'd2
  } march_val_t;

  localparam logic [2:0] M0 = 3'd0;
  localparam logic [2:0] M1 = 3'd1;
  localparam logic [2:0] M2 = 3'd2;
  localparam logic [2:0] M3 = 3'd3;
  localparam logic [2:0] M4 = 3'd4;
  localparam logic [2:0] M5 = 3'd5;

  // Only M3 and M4 walk the array downwards.
  function automatic logic elem_is_up(input logic [2:0] e);
    case (e)
      M3, M4:  elem_is_up = 1'b0;
      default: elem_is_up = 1'b1;
    endcase
  endfunction

  function automatic march_val_t elem_rd_val(input logic [2:0] e);
    case (e)
      M1, M3, M5: elem_rd_val = VAL_0;
      M2, M4:     elem_rd_val = VAL_1;
      default:    elem_rd_val = VAL_NONE;
    endcase
  endfunction

  function automatic march_val_t elem_wr_val(input logic [2:0] e);
    case (e)
      M0, M2, M4: elem_wr_val = VAL_0;
      M1, M3:     elem_wr_val = VAL_1;
      default:    elem_wr_val = VAL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/march_cminus_seq_if.sv
// march_ram_if: single-port RAM bus between the BIST sequencer and the RAM.
//   ram_addr  : RAM address
//   ram_wdata : RAM write data
//   ram_we    : write enable, active high
//   ramout    : RAM read data, valid the cycle after the address
// master = sequencer side, slave = RAM side.
interface march_ram_if #(
  parameter int size   = 6,
  parameter int length = 8
);
  logic [size-1:0]   ram_addr;
  logic [length-1:0] ram_wdata;
  logic              ram_we;
  logic [length-1:0] ramout;

  modport master (output ram_addr, output ram_wdata, output ram_we, input ramout);
  modport slave  (input ram_addr, input ram_wdata, input ram_we, output ramout);
endinterface

// File: rtl/march_cminus_seq_addr_gen.sv
// march_addr_gen: up/down address counter for the March sequencer.
//   clk, rst_n            : clock, async active-low reset
//   load_zero_i/load_max_i: load the counter with 0 / all-ones (load_zero wins)
//   step_i, up_i          : advance by one in the given direction
//   addr_o                : current address
//   first_o / last_o      : address is 0 / address is DEPTH-1
module march_addr_gen #(
  parameter int size = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_zero_i,
  input  logic            load_max_i,
  input  logic            step_i,
  input  logic            up_i,
  output logic [size-1:0] addr_o,
  output logic            first_o,
  output logic            last_o
);
  logic [size-1:0] cnt_q, cnt_d;

  // Next count; wrap never happens because the sequencer reloads at element ends.
  always_comb begin
    cnt_d = cnt_q;
    if (load_zero_i) begin
      cnt_d = {size{1'b0}};
    end else if (load_max_i) begin
      cnt_d = {size{1'b1}};
    end else if (step_i) begin
      cnt_d = up_i ? cnt_q + {{(size-1){1'b0}}, 1'b1} : cnt_q - {{(size-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= {size{1'b0}};
    else        cnt_q <= cnt_d;
  end

  assign addr_o  = cnt_q;
  assign first_o = (cnt_q == {size{1'b0}});
  assign last_o  = (cnt_q == {size{1'b1}});
endmodule

// File: rtl/march_cminus_seq.sv
// march_cminus_seq: March C- BIST sequencer with read-data checking.
//   clk, rst_n : clock, async active-low reset
//   ram        : RAM bus (master): address, write data, write enable, read data
//   start, bg  : begin a pass from IDLE/DONE; bg is the D0 background word
//   busy, done : pass in progress / pass finished (held until next start)
//   fail, fail_addr, fail_elem, fail_data : sticky fail and first-mismatch diagnostics
//   err_cnt    : saturating mismatch count
module march_cminus_seq
  import march_pkg::*;
#(
  parameter int size   = 6,
  parameter int length = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  march_ram_if.master       ram,
  input  logic              start,
  input  logic [length-1:0] bg,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [size-1:0]   fail_addr,
  output logic [2:0]        fail_elem,
  output logic [length-1:0] fail_data,
  output logic [7:0]        err_cnt
);
  march_state_t state_q, state_d;
  logic [2:0] elem_q, elem_d;
  logic phase_q, phase_d;               // 0: first op at an address, 1: write of an r,w pair
  logic [length-1:0] bg_q, bg_d;
  logic we_q, we_d;
  logic [length-1:0] wdata_q, wdata_d;
  logic busy_q, done_q;
  logic cmp_v_q;
  logic [length-1:0] exp_q;
  logic [size-1:0] cmp_addr_q;
  logic [2:0] cmp_elem_q;
  logic fail_q, fail_d;
  logic [size-1:0] fail_addr_q, fail_addr_d;
  logic [2:0] fail_elem_q, fail_elem_d;
  logic [length-1:0] fail_data_q, fail_data_d;
  logic [7:0] err_q, err_d;

  logic [size-1:0] addr_s;
  logic first_s, last_s, load_zero_s, load_max_s, step_s;
  logic run_s, start_go_s, has_rd_s, has_wr_s, addr_done_s, terminal_s, elem_end_s;
  logic op_rd_s, mismatch_s, nxt_wr_s;
  march_val_t rd_val_s, nxt_wr_val_s;
  logic [2:0] elem_nxt_s;

  march_addr_gen #(.size(size)) u_addr (
    .clk(clk), .rst_n(rst_n),
    .load_zero_i(load_zero_s), .load_max_i(load_max_s),
    .step_i(step_s), .up_i(elem_is_up(elem_q)),
    .addr_o(addr_s), .first_o(first_s), .last_o(last_s)
  );

  // Decode of the op currently on the bus.
  always_comb begin
    run_s       = (state_q == RUN);
    start_go_s  = start && ((state_q == IDLE) || (state_q == DONE));
    rd_val_s    = elem_rd_val(elem_q);
    has_rd_s    = (rd_val_s != VAL_NONE);
    has_wr_s    = (elem_wr_val(elem_q) != VAL_NONE);
    // An r,w element needs two ops per address; all others need one.
    addr_done_s = !(has_rd_s && has_wr_s && !phase_q);
    terminal_s  = elem_is_up(elem_q) ? last_s : first_s;
    elem_end_s  = run_s && addr_done_s && terminal_s;
    op_rd_s     = run_s && has_rd_s && !phase_q;
    elem_nxt_s  = elem_q + 3'd1;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start_go_s ? RUN : IDLE;
      RUN:     state_d = (elem_end_s && (elem_q == M5)) ? DRAIN : RUN;
      DRAIN:   state_d = DONE;
      DONE:    state_d = start_go_s ? RUN : DONE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: element/phase sequencing and address-counter control.
  always_comb begin
    elem_d      = elem_q;
    phase_d     = phase_q;
    load_zero_s = 1'b0;
    load_max_s  = 1'b0;
    step_s      = 1'b0;
    if (start_go_s) begin
      elem_d      = M0;
      phase_d     = 1'b0;
      load_zero_s = 1'b1;
    end else if (run_s) begin
      if (!addr_done_s) begin
        phase_d = 1'b1;
      end else if (terminal_s) begin
        phase_d = 1'b0;
        if (elem_q != M5) begin
          elem_d      = elem_nxt_s;
          load_zero_s = elem_is_up(elem_nxt_s);
          load_max_s  = !elem_is_up(elem_nxt_s);
        end else begin
          elem_d = elem_q;
        end
      end else begin
        phase_d = 1'b0;
        step_s  = 1'b1;
      end
    end else begin
      elem_d = elem_q;
    end
  end

  // Write enable/data are registered one op ahead so they line up with the address.
  always_comb begin
    bg_d         = start_go_s ? bg : bg_q;
    nxt_wr_val_s = elem_wr_val(elem_d);
    nxt_wr_s     = (state_d == RUN) && (nxt_wr_val_s != VAL_NONE) &&
                   (phase_d || (elem_rd_val(elem_d) == VAL_NONE));
    we_d         = nxt_wr_s;
    if (nxt_wr_s) wdata_d = (nxt_wr_val_s == VAL_1) ? ~bg_d : bg_d;
    else          wdata_d = wdata_q;
  end

  // Mismatch accounting; diagnostics are captured only for the first error of a pass.
  always_comb begin
    mismatch_s  = cmp_v_q && (ram.ramout != exp_q);
    err_d       = err_q;
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    fail_elem_d = fail_elem_q;
    fail_data_d = fail_data_q;
    if (start_go_s) begin
      err_d       = 8'h00;
      fail_d      = 1'b0;
      fail_addr_d = {size{1'b0}};
      fail_elem_d = 3'd0;
      fail_data_d = {length{1'b0}};
    end else if (mismatch_s) begin
      err_d  = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
      fail_d = 1'b1;
      if (!fail_q) begin
        fail_addr_d = cmp_addr_q;
        fail_elem_d = cmp_elem_q;
        fail_data_d = ram.ramout;
      end else begin
        fail_addr_d = fail_addr_q;
      end
    end else begin
      err_d = err_q;
    end
  end

  // Datapath, compare pipeline and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      elem_q      <= M0;
      phase_q     <= 1'b0;
      bg_q        <= {length{1'b0}};
      we_q        <= 1'b0;
      wdata_q     <= {length{1'b0}};
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cmp_v_q     <= 1'b0;
      exp_q       <= {length{1'b0}};
      cmp_addr_q  <= {size{1'b0}};
      cmp_elem_q  <= 3'd0;
      fail_q      <= 1'b0;
      fail_addr_q <= {size{1'b0}};
      fail_elem_q <= 3'd0;
      fail_data_q <= {length{1'b0}};
      err_q       <= 8'h00;
    end else begin
      elem_q      <= elem_d;
      phase_q     <= phase_d;
      bg_q        <= bg_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      busy_q      <= (state_d == RUN) || (state_d == DRAIN);
      done_q      <= (state_d == DONE);
      cmp_v_q     <= op_rd_s;
      exp_q       <= (rd_val_s == VAL_1) ? ~bg_q : bg_q;
      cmp_addr_q  <= addr_s;
      cmp_elem_q  <= elem_q;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      fail_elem_q <= fail_elem_d;
      fail_data_q <= fail_data_d;
      err_q       <= err_d;
    end
  end

  assign ram.ram_addr  = addr_s;
  assign ram.ram_we    = we_q;
  assign ram.ram_wdata = wdata_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign fail          = fail_q;
  assign fail_addr     = fail_addr_q;
  assign fail_elem     = fail_elem_q;
  assign fail_data     = fail_data_q;
  assign err_cnt       = err_q;
endmodule

// File: tb/tb_march_cminus_seq.sv
// Directed bench for march_cminus_seq with a behavioural RAM that can inject
// a stuck-at-1 cell (addr 5 bit 0) or a rising-transition fault (addr 63 bit 0).
module tb_march_cminus_seq;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] bg;
  logic       busy, done, fail;
  logic [5:0] fail_addr;
  logic [2:0] fail_elem;
  logic [7:0] fail_data, err_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int fault_mode = 0;

  logic [7:0] mem [0:63];
  logic [5:0] log_addr [0:700];
  logic       log_we   [0:700];
  logic [7:0] log_wd   [0:700];

  march_ram_if #(.size(6), .length(8)) ram_bus ();

  march_cminus_seq #(.size(6), .length(8)) dut (
    .clk(clk), .rst_n(rst_n), .ram(ram_bus), .start(start), .bg(bg),
    .busy(busy), .done(done), .fail(fail), .fail_addr(fail_addr),
    .fail_elem(fail_elem), .fail_data(fail_data), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] store_val(input logic [5:0] a, input logic [7:0] wd,
                                           input logic [7:0] old);
    logic [7:0] v;
    v = wd;
    if (fault_mode == 1 && a == 6'd5) v[0] = 1'b1;
    else if (fault_mode == 2 && a == 6'd63 && !old[0] && wd[0]) v[0] = 1'b0;
    return v;
  endfunction

  // Synchronous read-first RAM.
  always @(posedge clk) begin
    if (ram_bus.ram_we)
      mem[ram_bus.ram_addr] <= store_val(ram_bus.ram_addr, ram_bus.ram_wdata, mem[ram_bus.ram_addr]);
    ram_bus.ramout <= mem[ram_bus.ram_addr];
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts a pass and logs the bus each cycle until done (bounded).
  // Optional start pulses during RUN and an async reset at a given RUN cycle.
  task automatic run_pass(input logic [7:0] bgv, input int pulse_a, input int pulse_b,
                          input int rst_at, output int cycles, output int we_cnt);
    int k;
    bg = bgv; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    k = 1; we_cnt = 0; cycles = -1;
    while (k <= 700) begin
      log_addr[k] = ram_bus.ram_addr;
      log_we[k]   = ram_bus.ram_we;
      log_wd[k]   = ram_bus.ram_wdata;
      if (ram_bus.ram_we) we_cnt++;
      if (done) begin
        cycles = k - 1;
        break;
      end
      if (k == rst_at) begin
        rst_n = 1'b0; #1;
        check_eq("async_rst_outputs",
                 {18'd0, busy, done, fail, ram_bus.ram_we, err_cnt, ram_bus.ram_addr, ram_bus.ram_wdata,
                  fail_addr, fail_elem, fail_data}, 32'd0);
        cycles = k;
        break;
      end
      start = (k == pulse_a) || (k == pulse_b);
      @(posedge clk); #1; start = 1'b0;
      k++;
    end
  endtask

  initial begin
    int cyc, wec, bad;
    rst_n = 1'b0; start = 1'b0; bg = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy_done", {30'd0, busy, done}, 32'd0);
    check_eq("rst_fail_err", {23'd0, fail, err_cnt}, 32'd0);
    check_eq("rst_ram_bus", {17'd0, ram_bus.ram_we, ram_bus.ram_addr, ram_bus.ram_wdata}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Fault-free pass, bg=00.
    run_pass(8'h00, -1, -1, -1, cyc, wec);
    check_eq("t1_latency", cyc, 641);
    check_eq("t1_fail", fail, 1'b0);
    check_eq("t1_err_cnt", err_cnt, 8'd0);
    check_eq("t1_we_pulses", wec, 320);           // five write elements of 64 words
    check_eq("t1_busy_after", busy, 1'b0);
    check_eq("t1_first_op", {log_we[1], log_addr[1], log_wd[1]}, {1'b1, 6'd0, 8'h00});
    check_eq("t1_second_op", {log_we[2], log_addr[2]}, {1'b1, 6'd1});
    check_eq("t1_last_write", {log_we[576], log_addr[576], log_wd[576]}, {1'b1, 6'd0, 8'h00});
    check_eq("t1_m5_read", {log_we[577], log_addr[577]}, {1'b0, 6'd0});
    check_eq("t1_idle_bus", {ram_bus.ram_we, ram_bus.ram_addr}, {1'b0, 6'd63});

    // bg=55 fault-free: pattern and ordering.
    run_pass(8'h55, -1, -1, -1, cyc, wec);
    check_eq("t3_latency", cyc, 641);
    check_eq("t3_fail", fail, 1'b0);
    bad = 0;
    for (int i = 1; i <= 64; i++)
      if (!log_we[i] || log_addr[i] != 6'(i - 1) || log_wd[i] != 8'h55) bad++;
    check_eq("t3_m0_writes", bad, 0);
    check_eq("t3_m1_read0", {log_we[65], log_addr[65]}, {1'b0, 6'd0});
    check_eq("t3_m1_write0", {log_we[66], log_addr[66], log_wd[66]}, {1'b1, 6'd0, 8'hAA});
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      if (log_we[321 + 2*i] || log_addr[321 + 2*i] != 6'(63 - i)) bad++;
      if (!log_we[322 + 2*i] || log_addr[322 + 2*i] != 6'(63 - i) || log_wd[322 + 2*i] != 8'hAA) bad++;
    end
    check_eq("t3_m3_descending", bad, 0);

    // Stuck-at-1 on bit0 at addr 5.
    fault_mode = 1;
    run_pass(8'h00, -1, -1, -1, cyc, wec);
    check_eq("t2_fail", fail, 1'b1);
    check_eq("t2_fail_addr", fail_addr, 6'd5);
    check_eq("t2_fail_elem", fail_elem, 3'd1);
    check_eq("t2_fail_data", fail_data, 8'h01);
    check_eq("t2_err_cnt", err_cnt, 8'd3);

    // Restart from DONE, with start pulses during RUN ignored.
    fault_mode = 0;
    run_pass(8'h00, 10, 300, -1, cyc, wec);
    check_eq("t5_latency", cyc, 641);
    check_eq("t5_fail_cleared", fail, 1'b0);
    check_eq("t5_err_cleared", err_cnt, 8'd0);
    check_eq("t5_diag_cleared", {fail_addr, fail_elem, fail_data}, 17'd0);

    // Rising-transition fault at addr 63.
    fault_mode = 2;
    run_pass(8'h00, -1, -1, -1, cyc, wec);
    check_eq("t6_fail_addr", fail_addr, 6'd63);
    check_eq("t6_fail_elem", fail_elem, 3'd2);
    check_eq("t6_fail_data", fail_data, 8'hFE);
    check_eq("t6_err_cnt", err_cnt, 8'd2);

    // Async reset in the middle of a pass, then a clean pass.
    fault_mode = 0;
    run_pass(8'h00, -1, -1, 200, cyc, wec);
    check_eq("t4_reset_cycle", cyc, 200);
    repeat (2) @(posedge clk);
    #1;
    check_eq("t4_held_idle", {busy, done, ram_bus.ram_we}, 3'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_pass(8'h00, -1, -1, -1, cyc, wec);
    check_eq("t4_latency", cyc, 641);
    check_eq("t4_fail", fail, 1'b0);
    check_eq("t4_done", done, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
